// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package hazard_pkg;

    // Why the pipeline is stalled; the encoding is visible on stall_cause.
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LOAD_USE = 2'd1,
        BRANCH   = 2'd2,
        MULDIV   = 2'd3
    } hz_cause_t;

    // Mul/div occupancy tracker states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // $zero is hard-wired, so it can never carry a true dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_muldiv_tracker.sv
// Tracks occupancy of the multi-cycle mul/div unit after an issue from EX.
// Latency: busy for MULDIV_LAT cycles starting the cycle after issue; done pulses in the last one.
// Backpressure: none here; the top level stalls ID while busy, so issue during busy never occurs.
module muldiv_tracker
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic MulDiv_EX,
    output logic muldiv_busy,
    output logic muldiv_done
);

    md_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Next-state: load the latency on issue, count down while busy, return to idle after cnt==1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (MulDiv_EX) begin
                    state_d = BUSY;
                    cnt_d   = 4'(MULDIV_LAT);
                end
            end
            BUSY: begin
                // A second issue while busy is ignored: no reload.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and down-counter registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign muldiv_busy = (state_q == BUSY);
    // Suppressed during reset so an abandoned operation never reports completion.
    assign muldiv_done = muldiv_busy && (cnt_q == 4'd1) && !reset;

    // The ID-stage mdstall must keep a second mul/div from reaching EX while busy.
    a_no_issue_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(MulDiv_EX && state_q == BUSY));

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush generation for load-use, ID-branch and mul/div hazards, plus a stall-cycle counter.
// Latency: all stall/flush outputs are combinational (zero cycles); stall_cycles updates the edge after.
// Backpressure: a stall holds F/D and bubbles E, and always overrides a branch/jump flush of D.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic [4:0]       writereg_EX,
    input  logic [4:0]       writereg_M,
    input  logic             RegWrite_EX,
    input  logic             MemtoReg_EX,
    input  logic             MemtoReg_M,
    input  logic             Branch_ID,
    input  logic             PCSrc_ID,
    input  logic             Jump_ID,
    input  logic             MulDiv_ID,
    input  logic             MulDiv_EX,
    input  logic             HiLoRead_ID,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Flush_D,
    output logic             Flush_E,
    output hz_cause_t        stall_cause,
    output logic             muldiv_busy,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             ex_hits_id, m_hits_id;
    logic             lwstall, brstall, mdstall, stall;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    muldiv_tracker #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_tracker (
        .clk         (clk),
        .reset       (reset),
        .MulDiv_EX   (MulDiv_EX),
        .muldiv_busy (muldiv_busy),
        .muldiv_done (muldiv_done)
    );

    // Hazard detection and cause priority; everything is forced quiet while reset is held.
    always_comb begin
        ex_hits_id = (writereg_EX != REG_ZERO) &&
                     ((writereg_EX == Rs_ID) || (writereg_EX == Rt_ID));
        m_hits_id  = (writereg_M != REG_ZERO) &&
                     ((writereg_M == Rs_ID) || (writereg_M == Rt_ID));

        lwstall = !reset && MemtoReg_EX && ex_hits_id;
        brstall = !reset && Branch_ID &&
                  ((RegWrite_EX && ex_hits_id) || (MemtoReg_M && m_hits_id));
        mdstall = !reset && (MulDiv_ID || HiLoRead_ID) && (muldiv_busy || MulDiv_EX);
        stall   = lwstall || brstall || mdstall;

        stall_cause = NONE;
        if (lwstall) begin
            stall_cause = LOAD_USE;
        end else if (brstall) begin
            stall_cause = BRANCH;
        end else if (mdstall) begin
            stall_cause = MULDIV;
        end
    end

    assign Stall_F = stall;
    assign Stall_D = stall;
    assign Flush_E = stall;
    // A stalled branch is re-evaluated next cycle, so it must not flush yet.
    assign Flush_D = !reset && (PCSrc_ID || Jump_ID) && !stall;

    // Saturating increment: holds at all-ones instead of wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
